// File: rtl/mips_bus_arbiter.sv
// Two-master round-robin arbiter for the Avalon-style cpu_ram bus.
// Define MIPS_BUS_ARB_FIXED_PRIO_EN to make master 0 win every tie.
module mips_bus_arbiter #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [3:0]  m0_byteenable,
    input  logic [31:0] m0_writedata,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [3:0]  m1_byteenable,
    input  logic [31:0] m1_writedata,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [3:0]  s_byteenable,
    output logic [31:0] s_writedata,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_owner_q, last_owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_err_q, timeout_err_d;

    logic req0, req1, own_id, own_req, tie_pick;

    assign req0    = m0_read | m0_write;
    assign req1    = m1_read | m1_write;
    assign own_id  = (state_q == OWN1);
    assign own_req = own_id ? req1 : req0;

`ifdef MIPS_BUS_ARB_FIXED_PRIO_EN
    assign tie_pick = 1'b0;
`else
    assign tie_pick = ~last_owner_q;
`endif

    always_comb begin
        state_d       = state_q;
        last_owner_d  = last_owner_q;
        cnt_d         = '0;
        timeout_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = tie_pick ? OWN1 : OWN0;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (own_req && !s_waitrequest) begin
                    state_d      = IDLE;
                    last_owner_d = own_id;
                end else if (!own_req) begin
                    state_d = IDLE;
                end else if (TIMEOUT > 0) begin
                    // this stalled cycle is the TIMEOUT-th one of the grant
                    if (32'(cnt_q) + 32'd1 >= TIMEOUT) begin
                        state_d       = IDLE;
                        last_owner_d  = own_id;
                        timeout_err_d = 1'b1;
                    end else begin
                        cnt_d = (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            last_owner_q  <= 1'b1;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_owner_q  <= last_owner_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_byteenable   = '0;
        s_writedata    = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        unique case (state_q)
            OWN0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_byteenable   = m0_byteenable;
                s_writedata    = m0_writedata;
                m0_waitrequest = s_waitrequest;
            end
            OWN1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_byteenable   = m1_byteenable;
                s_writedata    = m1_writedata;
                m1_waitrequest = s_waitrequest;
            end
            default: ;
        endcase
    end

    assign grant       = {state_q == OWN1, state_q == OWN0};
    assign timeout_err = timeout_err_q;
    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU's Avalon-style memory bus (address/read/write/waitrequest/byteenable/writedata/readdata).
- Shares a single cpu_ram between master 0 (mips_cpu_bus) and master 1 (loader/DMA/bench driver).
- Grants one transaction at a time, with round-robin fairness and an optional stall watchdog.
- Sits between the masters and the RAM; the protocol on every side is unchanged.

Parameters:
- TIMEOUT, 0, slave-stall watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- m0_address  in  32  master 0 address (similarly m0_read in 1, m0_write in 1, m0_byteenable in 4, m0_writedata in 32)
- m0_waitrequest  out  1  stall to master 0
- m0_readdata  out  32  read data to master 0
- m1_address  in  32  master 1 address (similarly m1_read in 1, m1_write in 1, m1_byteenable in 4, m1_writedata in 32)
- m1_waitrequest  out  1  stall to master 1
- m1_readdata  out  32  read data to master 1
- s_address  out  32  to slave
- s_read  out  1  to slave
- s_write  out  1  to slave
- s_byteenable  out  4  to slave
- s_writedata  out  32  to slave
- s_waitrequest  in  1  from slave
- s_readdata  in  32  from slave
- grant  out  2  one-hot current owner, {m1,m0}; 00 when idle
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Request definition: reqN = mN_read | mN_write.
- FSM states:
  - IDLE: grant=00.
  - OWN0: grant=01.
  - OWN1: grant=10.
  - State is registered.
- Reset (reset=0, asynchronous): state=IDLE, last_owner=1, stall counter=0, timeout_err=0. Outputs immediately become s_read=0, s_write=0, grant=00, both mN_waitrequest=1.
- IDLE transitions:
  - Only req0 → OWN0.
  - Only req1 → OWN1.
  - Both requesting → the master that is not last_owner.
  - Neither requesting → stay in IDLE.
- IDLE outputs: s_read=s_write=0; s_address/s_byteenable/s_writedata=0.
- OWNn outputs: s_* are a combinational mux of master n's signals.
  - mn_waitrequest = s_waitrequest.
  - The other master's waitrequest = 1.
- Completion: in OWNn, a cycle with reqn=1 and s_waitrequest=0.
  - Next state = IDLE; last_owner=n.
  - One bubble cycle between consecutive grants.
  - Minimum latency from request to slave access is 1 cycle (IDLE→OWN); with a zero-wait slave, completion occurs in that same granted cycle.
- Abandon: in OWNn, reqn drops without completion → IDLE; last_owner unchanged.
- readdata: m0_readdata = m1_readdata = s_readdata (broadcast). It is valid only to the owner on its completion cycle.
- Watchdog (TIMEOUT>0):
  - Counter increments each OWN cycle with s_waitrequest=1.
  - Counter clears on any state change.
  - When counter reaches TIMEOUT: next state = IDLE, timeout_err=1 for one cycle, last_owner=n.
  - The owning master sees waitrequest=1 throughout.
  - TIMEOUT=0: counter is held at 0 and timeout_err stays 0.
- Simultaneous events:
  - Completion and timeout in the same cycle → completion wins, no error.
  - New request from the non-owner during OWN → held off (waitrequest=1) until the next IDLE arbitration.
- Widths: stall counter is $clog2(TIMEOUT+1) bits, minimum 1, saturating.

Optional Feature:
- Macro: MIPS_BUS_ARB_FIXED_PRIO_EN.
- Defined: in IDLE with both requesting, master 0 always wins; last_owner is ignored (still tracked).
- Undefined: round-robin as above.

Test Plan:
- Reset mid-transaction: in OWN1 with s_waitrequest=1, assert reset=0 → same cycle grant=00, s_read=0, m1_waitrequest=1; after release, req0 and req1 together → OWN0 first (last_owner reset to 1).
- Single master, zero-wait slave: m0_read@0x100 → grant=01 the next cycle, m0_waitrequest=0, m0_readdata=RAM[0x100]; following cycle grant=00.
- Contention round-robin: m0 and m1 both issue continuous reads → grants alternate 01,00,10,00,01… Each master completes 4 reads in 16 cycles with RAM_WAIT=0. With MIPS_BUS_ARB_FIXED_PRIO_EN defined → 01,00,01,00… and m1 starves.
- Write passthrough: m1_write, address 0x20, byteenable 4'b0011, writedata 0xDEADBEEF → s_* mirror exactly for the granted cycle; a subsequent m0_read of 0x20 returns the low 16 bits 0xBEEF merged with the prior upper bytes.
- Watchdog: TIMEOUT=8, slave holds s_waitrequest=1 → timeout_err pulses exactly 8 cycles after grant, grant→00, then a pending m1 is granted. With TIMEOUT=0 → no pulse after 100 stalled cycles.
- Abandon: m0 asserts read for 1 cycle while s_waitrequest=1 then drops → grant returns 00, no timeout_err, last_owner unchanged (a subsequent dual request still grants m0).
